imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch stage (read-only) and the memory stage (load/store).
- The memory read path is combinational: mem_addr in, mem_rdata out in the same cycle.
- This block grants the port, captures read data into registers, and stalls the loser.
- The data port has priority. A starvation counter forces a fetch grant after a bounded run of denials.

Parameters:
AW, 32, address width of all address ports
DW, 32, data width of all data ports
STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
if_req  input  1  fetch requests a read this cycle
if_addr  input  AW  fetch address
if_stall  output  1  combinational; if_req=1 and fetch not granted this cycle
if_valid  output  1  registered; if_rdata holds the word for the fetch granted last cycle
if_rdata  output  DW  registered fetch read data
dm_req  input  1  data port requests access this cycle
dm_we  input  1  1=write, 0=read; meaningful only with dm_req
dm_addr  input  AW  data address
dm_wdata  input  DW  write data
dm_stall  output  1  combinational; dm_req=1 and data port not granted this cycle
dm_valid  output  1  registered; read data ready, or write acknowledged, for the data grant last cycle
dm_rdata  output  DW  registered data read data; unchanged after a write grant
mem_addr  output  AW  address to memory
mem_we  output  1  memory write enable
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  combinational read data from memory

Behaviour:
- Grant is combinational, and at most one grant is issued per cycle.
- force_if = if_req && (starve_cnt == STARVE_MAX).
- gnt_dm = dm_req && !force_if.
- gnt_if = if_req && !gnt_dm.
- Memory drive:
  - gnt_dm: mem_addr=dm_addr, mem_we=dm_we, mem_wdata=dm_wdata.
  - gnt_if: mem_addr=if_addr, mem_we=0.
  - No grant: mem_addr=0, mem_we=0, mem_wdata=0.
- Latency: one cycle. On the edge ending a grant cycle:
  - Fetch grant: if_rdata<=mem_rdata and if_valid<=1.
  - Data read grant: dm_rdata<=mem_rdata and dm_valid<=1.
  - Data write grant: dm_valid<=1 and dm_rdata holds its value.
  - Valid pulses last exactly one cycle unless the next cycle is also granted to that port.
  - A stalled requester must hold req and addr stable. Stalls are not sticky; requests are re-evaluated every cycle.
- Starvation counter (4-bit starve_cnt):
  - Increments when if_req && !gnt_if.
  - Clears to 0 when gnt_if or !if_req.
  - Saturates at STARVE_MAX.
  - After a forced fetch grant the counter clears, so data wins again next cycle.
- FSM (owner of the response register), states IDLE, RSP_IF, RSP_DM:
  - Next state is RSP_DM if gnt_dm, RSP_IF if gnt_if, else IDLE.
  - Decodes: if_valid = (state==RSP_IF), dm_valid = (state==RSP_DM).
- Reset (rst_n=0 at edge):
  - state=IDLE, starve_cnt=0, if_rdata=0, dm_rdata=0.
  - Hence if_valid=0 and dm_valid=0 the following cycle.
  - A response pending at reset is discarded.
  - While rst_n=0, grants are still computed combinationally.
  - rst_n has priority over all other edge actions.
- Boundaries:
  - Both requests with starve_cnt<STARVE_MAX: data wins, if_stall=1.
  - STARVE_MAX=1: strict alternation under continuous contention.
  - Neither request: no memory activity, state->IDLE.
  - Address values are passed through unchanged, with no alignment or range checks.

Test Plan:
- Fetch only, if_addr=5,15,25 on consecutive cycles with memory word[a]=a+100 -> if_valid=1 from cycle 2; if_rdata=105,115,125; if_stall=0 throughout.
- Continuous dm_req read at addr 55 with if_req=1 at addr 60, STARVE_MAX=4:
  - Cycles 1-4: data granted, if_stall=1.
  - Cycle 5: fetch forced and granted, dm_stall=1.
  - Cycle 6: if_rdata=160; data granted again.
- Data write dm_addr=21, dm_wdata=0xDEADBEEF, no fetch:
  - Grant cycle: mem_we=1, mem_addr=21.
  - Next cycle: dm_valid=1 and dm_rdata unchanged.
  - A fetch read of 21 then returns 0xDEADBEEF.
- Fetch granted at addr 0 in cycle N, rst_n=0 in cycle N+1 -> if_valid=0 in cycle N+2, starve_cnt=0, if_rdata=0.
- STARVE_MAX=1 with both ports requesting continuously -> grants alternate DM,IF,DM,IF; each port sees valid every other cycle.
- Idle cycle (no requests) -> mem_addr=0, mem_we=0, if_stall=0 and dm_stall=0; both valids=0 the next cycle.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch stage, data stage, shared memory and the arbiter.
// slave = arbiter side, master = requesters/memory side.
interface imem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_stall;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_stall;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_stall, if_valid, if_rdata, dm_stall, dm_valid, dm_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_stall, if_valid, if_rdata, dm_stall, dm_valid, dm_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Single-port memory arbiter: data port has priority, fetch is forced through
// after STARVE_MAX consecutive denials. Read data is registered one cycle later.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | no grant last cycle, both valids low
// ST_RSP_IF | fetch granted last cycle, if_rdata/if_valid presented
// ST_RSP_DM | data port granted last cycle, dm_valid presented
module imem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RSP_IF = 2'd1,
    ST_RSP_DM = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_starve_cnt;
  logic [3:0]    w_starve_nxt;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;

  logic w_force_if;
  logic w_gnt_dm;
  logic w_gnt_if;

  assign w_force_if = bus.if_req && (r_starve_cnt == 4'(STARVE_MAX));
  assign w_gnt_dm   = bus.dm_req && !w_force_if;
  assign w_gnt_if   = bus.if_req && !w_gnt_dm;

  always_comb begin
    w_state_nxt  = ST_IDLE;
    w_starve_nxt = 4'd0;
    if (w_gnt_dm) begin
      w_state_nxt = ST_RSP_DM;
    end else if (w_gnt_if) begin
      w_state_nxt = ST_RSP_IF;
    end
    // Denied fetch counts up, saturating; any fetch grant or idle fetch clears it.
    if (bus.if_req && !w_gnt_if) begin
      w_starve_nxt = (r_starve_cnt == 4'(STARVE_MAX)) ? r_starve_cnt : r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 4'd0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_gnt_if) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_gnt_dm && !bus.dm_we) begin
        r_dm_rdata <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (w_gnt_dm) begin
      bus.mem_addr  = bus.dm_addr;
      bus.mem_we    = bus.dm_we;
      bus.mem_wdata = bus.dm_wdata;
    end else if (w_gnt_if) begin
      bus.mem_addr  = bus.if_addr;
    end
  end

  assign bus.if_stall = bus.if_req && !w_gnt_if;
  assign bus.dm_stall = bus.dm_req && !w_gnt_dm;
  assign bus.if_valid = (r_state == ST_RSP_IF);
  assign bus.dm_valid = (r_state == ST_RSP_DM);
  assign bus.if_rdata = r_if_rdata;
  assign bus.dm_rdata = r_dm_rdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: STARVE_MAX=4 instance driven from a vector table
// against a reference model/scoreboard, plus a STARVE_MAX=1 alternation instance.
module tb_imem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.AW(32), .DW(32)) b0 ();
  imem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();

  imem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  imem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  // Memory for u0: word[a] = a+100, writable. u1 sees a fixed addr+100 pattern.
  logic [31:0] mem [64];
  assign b0.mem_rdata = mem[b0.mem_addr[5:0]];
  always @(posedge clk) if (b0.mem_we) mem[b0.mem_addr[5:0]] <= b0.mem_wdata;
  assign b1.mem_rdata = b1.mem_addr + 32'd100;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        if_v;
    logic        dm_v;
    logic [31:0] if_d;
    logic [31:0] dm_d;
  } rsp_t;
  rsp_t sbq[$];

  int          m_starve = 0;
  logic [31:0] m_if_d = '0;
  logic [31:0] m_dm_d = '0;

  logic        s_ifs, s_dms, s_ifv;
  logic [31:0] s_ifd;
  logic        s1_ifs, s1_dms, s1_ifv, s1_dmv;
  logic [31:0] s1_ifd, s1_dmd;

  task automatic step();
    rsp_t r;
    logic frc, gdm, gif;
    @(negedge clk);
    if (sbq.size() > 0) begin
      r = sbq.pop_front();
      chk("if_valid", b0.if_valid, r.if_v);
      chk("dm_valid", b0.dm_valid, r.dm_v);
      chk("if_rdata", b0.if_rdata, r.if_d);
      chk("dm_rdata", b0.dm_rdata, r.dm_d);
    end
    frc = b0.if_req && (m_starve == 4);
    gdm = b0.dm_req && !frc;
    gif = b0.if_req && !gdm;
    chk("if_stall",  b0.if_stall, b0.if_req && !gif);
    chk("dm_stall",  b0.dm_stall, b0.dm_req && !gdm);
    chk("mem_addr",  b0.mem_addr, gdm ? b0.dm_addr : (gif ? b0.if_addr : 32'd0));
    chk("mem_we",    b0.mem_we, gdm && b0.dm_we);
    chk("mem_wdata", b0.mem_wdata, gdm ? b0.dm_wdata : 32'd0);
    s_ifs = b0.if_stall; s_dms = b0.dm_stall; s_ifv = b0.if_valid; s_ifd = b0.if_rdata;
    s1_ifs = b1.if_stall; s1_dms = b1.dm_stall; s1_ifv = b1.if_valid;
    s1_dmv = b1.dm_valid; s1_ifd = b1.if_rdata; s1_dmd = b1.dm_rdata;
    if (!rst_n) begin
      m_starve = 0; m_if_d = '0; m_dm_d = '0;
      r = '{if_v: 1'b0, dm_v: 1'b0, if_d: 32'd0, dm_d: 32'd0};
    end else begin
      if (gif) m_if_d = mem[b0.if_addr[5:0]];
      if (gdm && !b0.dm_we) m_dm_d = mem[b0.dm_addr[5:0]];
      r = '{if_v: gif, dm_v: gdm, if_d: m_if_d, dm_d: m_dm_d};
      if (b0.if_req && !gif) m_starve = (m_starve == 4) ? 4 : m_starve + 1;
      else m_starve = 0;
    end
    sbq.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic ifr, input logic [31:0] ifa,
                       input logic dmr, input logic dmwe, input logic [31:0] dma,
                       input logic [31:0] dmd);
    rst_n = rst; b0.if_req = ifr; b0.if_addr = ifa;
    b0.dm_req = dmr; b0.dm_we = dmwe; b0.dm_addr = dma; b0.dm_wdata = dmd;
  endtask

  typedef struct {
    logic        rst;
    logic        ifr;
    logic [31:0] ifa;
    logic        dmr;
    logic        dmwe;
    logic [31:0] dma;
    logic [31:0] dmd;
    logic        e_ifs;
    logic        e_dms;
    logic        cki;
    logic [31:0] e_ifd;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rst, input logic ifr, input logic [31:0] ifa,
                     input logic dmr, input logic dmwe, input logic [31:0] dma,
                     input logic [31:0] dmd, input logic e_ifs, input logic e_dms,
                     input logic cki, input logic [31:0] e_ifd);
    vecs.push_back('{rst: rst, ifr: ifr, ifa: ifa, dmr: dmr, dmwe: dmwe, dma: dma,
                     dmd: dmd, e_ifs: e_ifs, e_dms: e_dms, cki: cki, e_ifd: e_ifd});
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = 32'(a + 100);
    b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0;
    b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    @(posedge clk); #1;
    step(); step();

    // fetch-only stream, with registered data checked a cycle later
    add(1, 1,  5, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 15, 0, 0,  0, 0, 0, 0, 1, 105);
    add(1, 1, 25, 0, 0,  0, 0, 0, 0, 1, 115);
    // contention: data wins 4 times, fetch forced on the 5th
    add(1, 1, 60, 1, 0, 55, 0, 1, 0, 1, 125);
    add(1, 1, 60, 1, 0, 55, 0, 1, 0, 0, 0);
    add(1, 1, 60, 1, 0, 55, 0, 1, 0, 0, 0);
    add(1, 1, 60, 1, 0, 55, 0, 1, 0, 0, 0);
    add(1, 1, 60, 1, 0, 55, 0, 0, 1, 0, 0);
    add(1, 1, 60, 1, 0, 55, 0, 1, 0, 1, 160);
    add(1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
    // write then read back through the fetch port
    add(1, 0,  0, 1, 1, 21, 32'hDEADBEEF, 0, 0, 0, 0);
    add(1, 1, 21, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 0,  0, 0, 0,  0, 0, 0, 0, 1, 32'hDEADBEEF);
    add(1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ifr, vecs[i].ifa, vecs[i].dmr, vecs[i].dmwe,
            vecs[i].dma, vecs[i].dmd);
      step();
      chk($sformatf("vec%0d_if_stall", i), s_ifs, vecs[i].e_ifs);
      chk($sformatf("vec%0d_dm_stall", i), s_dms, vecs[i].e_dms);
      if (vecs[i].cki) chk($sformatf("vec%0d_if_rdata", i), s_ifd, vecs[i].e_ifd);
    end

    // fetch grant then reset: response discarded, data cleared
    drive(1, 1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0); step();
    chk("rst_pending_valid_seen", s_ifv, 1'b1);
    drive(1, 0, 0, 0, 0, 0, 0); step();
    chk("rst_if_valid", s_ifv, 1'b0);
    chk("rst_if_rdata", s_ifd, 32'd0);

    // build up starvation, reset, then fetch must wait a full 4 denials again
    for (int k = 0; k < 3; k++) begin drive(1, 1, 60, 1, 0, 55, 0); step(); end
    drive(0, 1, 60, 1, 0, 55, 0); step();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 60, 1, 0, 55, 0); step();
      chk($sformatf("post_rst_denied%0d", k), s_ifs, 1'b1);
    end
    drive(1, 1, 60, 1, 0, 55, 0); step();
    chk("post_rst_forced", s_ifs, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 0); step(); step();

    // STARVE_MAX=1: strict alternation DM,IF,DM,IF...
    b1.if_req = 1'b1; b1.if_addr = 32'd7; b1.dm_req = 1'b1; b1.dm_addr = 32'd9;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("alt%0d_if_stall", k), s1_ifs, (k % 2) == 0);
      chk($sformatf("alt%0d_dm_stall", k), s1_dms, (k % 2) == 1);
      if (k > 0) begin
        chk($sformatf("alt%0d_dm_valid", k), s1_dmv, (k % 2) == 1);
        chk($sformatf("alt%0d_if_valid", k), s1_ifv, (k % 2) == 0);
        if ((k % 2) == 1) chk($sformatf("alt%0d_dm_rdata", k), s1_dmd, 32'd109);
        else              chk($sformatf("alt%0d_if_rdata", k), s1_ifd, 32'd107);
      end
    end
    b1.if_req = 1'b0; b1.dm_req = 1'b0;
    step();
    step();
    chk("alt_idle_if_valid", s1_ifv, 1'b0);
    chk("alt_idle_dm_valid", s1_dmv, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
